// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel valid/ready arbiter feeding one registered output stage.
//
// Selection modes (mode): 00/11 fixed priority (lowest index wins),
// 01 round-robin from rr pointer, 10 manual (sel, no fallback).
// Once a non-last beat is accepted, the source channel holds the grant
// until its last beat is accepted (packet lock).
//
// State table:
//   state   | meaning
//   ST_IDLE | no packet in flight; grant chosen by mode
//   ST_LOCK | mid-packet; only lock_ch_q is eligible, mode/sel ignored
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         grant enable; 0 blocks new beats
//   mode       selection mode
//   sel        manual channel index
//   in_data    packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   out_data   registered data
//   out_ch     registered source channel index
//   out_last   registered last flag
//   out_valid  registered valid
//   out_ready  downstream ready
module arb_mux_n #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 3,
   parameter int SEL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH-1:0]       in_last,
   output logic [N_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             grant_vld;
   logic [SEL_W-1:0] grant_ch;
   logic [SEL_W:0]   rr_sum;
   logic [SEL_W:0]   rr_next;
   logic             load_ok;
   logic             xfer;
   logic             xfer_last;
   logic [WIDTH-1:0] xfer_data;

   // Grant selection. Loops scan downward so the lowest index (or the
   // smallest offset from the rr pointer) is the last assignment and wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      rr_sum    = '0;
      if (state_q == ST_LOCK) begin
         grant_vld = in_valid[lock_ch_q];
         grant_ch  = lock_ch_q;
      end else begin
         case (mode)
            2'b01: begin
               for (int i = N_CH - 1; i >= 0; i--) begin
                  rr_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
                  if (rr_sum >= (SEL_W+1)'(N_CH))
                     rr_sum = rr_sum - (SEL_W+1)'(N_CH);
                  if (in_valid[rr_sum[SEL_W-1:0]]) begin
                     grant_vld = 1'b1;
                     grant_ch  = rr_sum[SEL_W-1:0];
                  end
               end
            end
            2'b10: begin
               // Out-of-range sel (non power-of-two N_CH) grants nothing.
               if ({1'b0, sel} < (SEL_W+1)'(N_CH)) begin
                  if (in_valid[sel]) begin
                     grant_vld = 1'b1;
                     grant_ch  = sel;
                  end
               end
            end
            default: begin
               for (int i = N_CH - 1; i >= 0; i--) begin
                  if (in_valid[i]) begin
                     grant_vld = 1'b1;
                     grant_ch  = SEL_W'(i);
                  end
               end
            end
         endcase
      end
   end

   assign load_ok   = !out_valid || out_ready;
   assign xfer      = en && load_ok && grant_vld;
   assign in_ready  = xfer ? (N_CH'(1) << grant_ch) : '0;
   assign xfer_last = in_last[grant_ch];
   assign xfer_data = in_data[grant_ch*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         lock_ch_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      rr_ptr_d  = rr_ptr_q;
      rr_next   = {1'b0, grant_ch} + (SEL_W+1)'(1);
      case (state_q)
         ST_IDLE: begin
            if (xfer && !xfer_last) begin
               state_d   = ST_LOCK;
               lock_ch_d = grant_ch;
            end
         end
         ST_LOCK: begin
            if (xfer && xfer_last)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Pointer moves only at packet boundaries, whatever the mode.
      if (xfer && xfer_last) begin
         if (rr_next >= (SEL_W+1)'(N_CH))
            rr_ptr_d = '0;
         else
            rr_ptr_d = rr_next[SEL_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= xfer_data;
         out_ch    <= grant_ch;
         out_last  <= xfer_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arb_mux_n.sv
module tb_arb_mux_n;
   localparam int N_CH  = 4;
   localparam int WIDTH = 3;
   localparam int SEL_W = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  en = 1'b0;
   logic [1:0]            mode = 2'b00;
   logic [SEL_W-1:0]      sel = '0;
   logic [N_CH*WIDTH-1:0] in_data = '0;
   logic [N_CH-1:0]       in_valid = '0;
   logic [N_CH-1:0]       in_last = '0;
   logic [N_CH-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_ch;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   arb_mux_n #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Reference model: packet owner (-1 = none), rr pointer, output register.
   int m_lock;
   int m_rr;
   int m_ov;
   int m_od;
   int m_och;
   int m_ol;

   function automatic int exp_grant();
      int c;
      if (m_lock >= 0) return in_valid[m_lock] ? m_lock : -1;
      if (mode == 2'b01) begin
         for (int i = 0; i < N_CH; i++) begin
            c = (m_rr + i) % N_CH;
            if (in_valid[c]) return c;
         end
         return -1;
      end
      if (mode == 2'b10) begin
         if (int'(sel) < N_CH && in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int i = 0; i < N_CH; i++)
         if (in_valid[i]) return i;
      return -1;
   endfunction

   function automatic logic [N_CH-1:0] exp_ready();
      int g;
      logic [N_CH-1:0] r;
      g = exp_grant();
      r = '0;
      if (en && (m_ov == 0 || out_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int g;
      if (!rst_n) begin
         m_lock = -1; m_rr = 0; m_ov = 0; m_od = 0; m_och = 0; m_ol = 0;
      end else if (exp_ready() != '0) begin
         g = exp_grant();
         m_ov = 1;
         m_od = int'(in_data[g*WIDTH +: WIDTH]);
         m_och = g;
         m_ol = int'(in_last[g]);
         if (in_last[g]) begin
            m_lock = -1;
            m_rr = (g + 1) % N_CH;
         end else begin
            m_lock = g;
         end
      end else if (out_ready) begin
         m_ov = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input int val);
      in_data[ch*WIDTH +: WIDTH] = WIDTH'(val);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = '0; in_last = '0; en = 1'b1; out_ready = 1'b1;
      mode = 2'b00; sel = '0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%0b d=%0h ch=%0d l=%0b, want all 0",
                  out_valid, out_data, out_ch, out_last);
      end
      checks++;
      if (in_ready !== '0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, want 0000", in_ready);
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      in_valid = 4'b1010; in_last = 4'b1111;
      set_data(1, 5); set_data(3, 6);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++;
         $display("FAIL fixed_ready: got %b, want 0010", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 3'h5 || out_ch !== 2'd1) begin
         errors++;
         $display("FAIL fixed_first: got v=%0b d=%0h ch=%0d, want v=1 d=5 ch=1",
                  out_valid, out_data, out_ch);
      end
      in_valid = 4'b1000;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++;
         $display("FAIL fixed_ready2: got %b, want 1000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 3'h6 || out_ch !== 2'd3) begin
         errors++;
         $display("FAIL fixed_second: got v=%0b d=%0h ch=%0d, want v=1 d=6 ch=3",
                  out_valid, out_data, out_ch);
      end
      in_valid = '0;
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      mode = 2'b01; in_valid = 4'b1111; in_last = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         set_data(i % N_CH, i);
         tick();
         checks++;
         if (out_valid !== 1'b1 || int'(out_ch) != i % N_CH) begin
            errors++;
            $display("FAIL rr_seq[%0d]: got v=%0b ch=%0d, want v=1 ch=%0d",
                     i, out_valid, out_ch, i % N_CH);
         end
      end
      in_valid = '0;
      tick();
   endtask

   task automatic test_packet_lock();
      do_reset();
      mode = 2'b01; in_valid = 4'b0010; in_last = 4'b1111;
      tick();
      in_valid = 4'b0111;
      for (int b = 0; b < 3; b++) begin
         in_last = (b == 2) ? 4'b1111 : 4'b1011;
         set_data(2, b + 1);
         tick();
         checks++;
         if (out_ch !== 2'd2 || out_last !== (b == 2) || int'(out_data) != b + 1) begin
            errors++;
            $display("FAIL lock_beat[%0d]: got ch=%0d l=%0b d=%0h, want ch=2 l=%0b d=%0h",
                     b, out_ch, out_last, out_data, (b == 2), b + 1);
         end
      end
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL lock_next_ready: got %b, want 0001", in_ready);
      end
      tick();
      checks++;
      if (out_ch !== 2'd0) begin
         errors++;
         $display("FAIL lock_next_ch: got %0d, want 0", out_ch);
      end
      in_valid = '0;
      tick();
   endtask

   task automatic test_manual();
      do_reset();
      mode = 2'b10; sel = 2'd3; in_valid = 4'b0111; in_last = 4'b1111;
      #1;
      checks++;
      if (in_ready !== '0) begin
         errors++;
         $display("FAIL manual_no_grant: got %b, want 0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL manual_idle_out: got v=%0b, want 0", out_valid);
      end
      in_valid = 4'b1111; set_data(3, 7);
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++;
         $display("FAIL manual_ready: got %b, want 1000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 3'h7 || out_ch !== 2'd3) begin
         errors++;
         $display("FAIL manual_out: got v=%0b d=%0h ch=%0d, want v=1 d=7 ch=3",
                  out_valid, out_data, out_ch);
      end
      in_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      int q[$];
      int d0;
      do_reset();
      mode = 2'b00; in_valid = 4'b0001; in_last = 4'b1111; out_ready = 1'b0;
      d0 = int'($urandom_range(0, 7));
      set_data(0, d0);
      q.push_back(d0);
      tick();
      set_data(0, (d0 + 1) % 8);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (in_ready !== '0 || out_valid !== 1'b1 || int'(out_data) != d0) begin
            errors++;
            $display("FAIL stall[%0d]: got rdy=%b v=%0b d=%0h, want rdy=0000 v=1 d=%0h",
                     i, in_ready, out_valid, out_data, d0);
         end
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         out_ready = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
         in_valid = (i < 32) ? 4'($urandom_range(0, 1)) : 4'b0000;
         set_data(0, int'($urandom_range(0, 7)));
         #1;
         checks++;
         if (in_ready !== exp_ready()) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %b, want %b", i, in_ready, exp_ready());
         end
         if (m_ov != 0 && out_ready) begin
            checks++;
            if (q.size() == 0 || int'(out_data) != q[0]) begin
               errors++;
               $display("FAIL bp_scoreboard[%0d]: got d=%0h, want %0h (queued %0d)",
                        i, out_data, (q.size() > 0) ? q[0] : -1, q.size());
            end
            if (q.size() > 0) void'(q.pop_front());
         end
         if (exp_ready()[0]) q.push_back(int'(in_data[WIDTH-1:0]));
         tick();
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got left=%0d v=%0b, want left=0 v=0", q.size(), out_valid);
      end
   endtask

   task automatic test_en_lock_reset();
      do_reset();
      mode = 2'b00; in_valid = 4'b0010; in_last = 4'b0000; set_data(1, 2);
      tick();
      en = 1'b0; in_valid = 4'b0011; in_last = 4'b0001;
      #1;
      checks++;
      if (in_ready !== '0) begin
         errors++;
         $display("FAIL en_block: got %b, want 0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_drain: got v=%0b, want 0", out_valid);
      end
      tick();
      en = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++;
         $display("FAIL en_resume_lock: got %b, want 0010", in_ready);
      end
      in_last = 4'b0011; set_data(1, 4);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_last !== 1'b1 || out_data !== 3'h4) begin
         errors++;
         $display("FAIL en_resume_out: got v=%0b ch=%0d l=%0b d=%0h, want v=1 ch=1 l=1 d=4",
                  out_valid, out_ch, out_last, out_data);
      end
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL en_after_packet: got %b, want 0001", in_ready);
      end
      in_valid = 4'b0010; in_last = 4'b0000;
      tick();
      rst_n = 1'b0;
      in_valid = '0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || out_last !== 1'b0 ||
          in_ready !== '0) begin
         errors++;
         $display("FAIL midpkt_reset: got v=%0b d=%0h ch=%0d l=%0b rdy=%b, want all 0",
                  out_valid, out_data, out_ch, out_last, in_ready);
      end
      tick();
      rst_n = 1'b1;
      in_valid = 4'b0011; in_last = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL reset_unlock: got %b, want 0001", in_ready);
      end
      in_valid = '0;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 7) != 0);
         mode      = 2'($urandom_range(0, 3));
         sel       = SEL_W'($urandom_range(0, N_CH - 1));
         in_valid  = (i % 50 < 5) ? 4'b1111 : 4'($urandom_range(0, 15));
         in_last   = 4'($urandom_range(0, 15));
         in_data   = (N_CH*WIDTH)'($urandom());
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if (in_ready !== exp_ready() || $countones(in_ready) > 1) begin
            errors++;
            $display("FAIL rand_ready[%0d]: got %b, want %b", i, in_ready, exp_ready());
         end
         tick();
         checks++;
         if (int'(out_valid) != m_ov || int'(out_data) != m_od ||
             int'(out_ch) != m_och || int'(out_last) != m_ol) begin
            errors++;
            $display("FAIL rand_out[%0d]: got v=%0b d=%0h ch=%0d l=%0b, want v=%0d d=%0h ch=%0d l=%0d",
                     i, out_valid, out_data, out_ch, out_last, m_ov, m_od, m_och, m_ol);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_packet_lock();
      test_manual();
      test_backpressure();
      test_en_lock_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised successor to the team's 4-to-1 enabled mux. Selects one of N_CH valid/ready input channels and forwards its data into a single registered output stage.
- Three selection modes: fixed priority, round-robin, and manual select (the legacy sel/en behaviour).
- Packet locking: a channel keeps the grant until its last beat is accepted.
- Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 3, data bits per channel.
- SEL_W, 2, channel index width; must equal clog2(N_CH).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  grant enable; 0 blocks new beats entering the output register.
- mode  input  2  00 fixed priority, 01 round-robin, 10 manual (sel), 11 same as 00.
- sel  input  SEL_W  channel index used in manual mode.
- in_data  input  N_CH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_last  input  N_CH  per-channel end-of-packet flag; qualified by valid.
- in_ready  output  N_CH  per-channel ready (combinational); at most one bit high.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  registered index of the source channel.
- out_last  output  1  registered last flag.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, out_last=0, rr pointer=0, FSM=IDLE, in_ready=0.
- Output register load:
  - load_ok = !out_valid || out_ready.
  - A beat from channel k transfers when in_valid[k] && in_ready[k].
  - in_ready[k] = en && load_ok && (k == grant) && in_valid[k]. All in_ready bits are 0 when nothing is granted.
- Latency: 1 cycle from input transfer to out_valid=1.
- Throughput: 1 beat/cycle while out_ready=1.
- Output drain: if out_ready=1 and no transfer occurs, out_valid drops to 0 next cycle; out_data, out_ch and out_last hold their last values.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals are stable.
- Grant selection in IDLE:
  - mode 00/11: lowest-index valid channel wins.
  - mode 01: first valid channel searching upward from the rr pointer, wrapping N_CH-1 -> 0.
  - mode 10: grant=sel, only if in_valid[sel]. No fallback to other channels.
- FSM has two states, IDLE and LOCK(ch):
  - IDLE -> LOCK(k) on a transfer from k with in_last[k]=0.
  - LOCK(k): only channel k is eligible. mode and sel changes are ignored. A transfer with in_last[k]=1 returns to IDLE.
  - IDLE stays IDLE on a transfer with in_last=1 (single-beat packet).
- RR pointer update: on every transfer with last=1 from channel k, pointer = (k+1) mod N_CH, in all modes.
  - Pointer is unchanged by non-last beats and by stalls.
- en=0 while in LOCK: no transfers; lock and pointer are held. The output register still drains.
- Boundary conditions:
  - out_valid=1 with out_ready=1 and a new transfer in the same cycle: back-to-back load with no bubble.
  - Granted channel deasserts valid mid-packet: no transfer; lock is held.
  - sel out of range (N_CH not a power of 2) in mode 10: no grant.
  - Reset mid-packet: lock is dropped and FSM=IDLE; any partially forwarded packet is lost.
  - Simultaneous valid on all channels: exactly one in_ready is high.

Test Plan:
- Reset then mode=00, en=1, out_ready=1, in_valid=4'b1010, all last=1, data ch1=3'h5, ch3=3'h6 -> in_ready=4'b0010. Next cycle out_valid=1, out_data=5, out_ch=1. Ch1 then drops valid, so the following cycle gives out_data=6, out_ch=3.
- Mode=01, in_valid=4'b1111 held, all last=1, out_ready=1 -> out_ch sequence 0,1,2,3,0,1.
- Mode=01, ch2 sends 3-beat packet (last on beat 3) while ch0/ch1 are valid -> three consecutive out_ch=2 beats with out_last=1 only on the third; next grant goes to ch3 (or wraps to ch0 if ch3 is idle).
- Mode=10, sel=3, in_valid[3]=0, others valid -> in_ready=0 and out_valid stays 0. Setting in_valid[3]=1 with data 3'h7 -> out_data=7, out_ch=3 one cycle later.
- out_ready=0 for 5 cycles with ch0 valid -> out_valid=1 and out_data stable, in_ready=0. Raising out_ready -> one beat per cycle, no loss or duplication (scoreboard).
- en=0 mid-packet (LOCK on ch1) -> no transfers, output drains to out_valid=0. en=1 resumes ch1 ahead of a valid ch0. Asserting rst_n=0 mid-packet -> all outputs 0 immediately, FSM=IDLE.
